qspi_xip_arbiter: RTL and testbench

- Shares one qspi_core between two requesters:
  - port 0: instruction fetch, read-only.
  - port 1: data, read/write.
- Arbitrates round-robin and programs the core over its register bus: CFG, WDATA, ADDR, CMD, then CTRL start.
- Polls core status until idle and returns read data to the winning requester.
- Sits between the CPU-side memory ports and qspi_core.

---
 rtl/qspi_xip_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_qspi_xip_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_xip_arbiter.sv
// Round-robin arbiter sharing one qspi_core between an instruction-fetch port and a data port.
// Optional status-poll timeout is enabled with `define QSPI_ARB_TIMEOUT_EN (adds POLL_MAX and err_o).
module qspi_xip_arbiter #(
   parameter logic [31:0] CFG_WORD = 32'h0F20_8182,
   parameter logic [7:0]  RD_CMD   = 8'hEB,
   parameter logic [7:0]  WR_CMD   = 8'h32
`ifdef QSPI_ARB_TIMEOUT_EN
   ,
   parameter int unsigned POLL_MAX = 1024
`endif
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        p0_req_i,
   input  logic [23:0] p0_addr_i,
   output logic        p0_gnt_o,
   output logic        p0_rvalid_o,
   output logic [31:0] p0_rdata_o,
   input  logic        p1_req_i,
   input  logic        p1_we_i,
   input  logic [23:0] p1_addr_i,
   input  logic [31:0] p1_wdata_i,
   output logic        p1_gnt_o,
   output logic        p1_rvalid_o,
   output logic [31:0] p1_rdata_o,
   output logic        core_we_o,
   output logic        core_re_o,
   output logic [23:0] core_addr_o,
   output logic [31:0] core_wdata_o,
   input  logic [31:0] core_rdata_i,
`ifdef QSPI_ARB_TIMEOUT_EN
   output logic        err_o,
`endif
   output logic        busy_o
);

   localparam logic [3:0] S_INIT  = 4'd0;
   localparam logic [3:0] S_IDLE  = 4'd1;
   localparam logic [3:0] S_GRANT = 4'd2;
   localparam logic [3:0] S_WDAT  = 4'd3;
   localparam logic [3:0] S_ADDR  = 4'd4;
   localparam logic [3:0] S_CMD   = 4'd5;
   localparam logic [3:0] S_START = 4'd6;
   localparam logic [3:0] S_CLRS  = 4'd7;
   localparam logic [3:0] S_POLL  = 4'd8;
   localparam logic [3:0] S_RDAT  = 4'd9;
   localparam logic [3:0] S_RESP  = 4'd10;
`ifdef QSPI_ARB_TIMEOUT_EN
   localparam logic [3:0] S_ABRT  = 4'd11;
   localparam int unsigned PCNT_W = $clog2(POLL_MAX + 1);
`endif

   localparam logic [23:0] A_CFG    = 24'h00_0000;
   localparam logic [23:0] A_WDATA  = 24'h00_0004;
   localparam logic [23:0] A_RDATA  = 24'h00_0008;
   localparam logic [23:0] A_ADDR   = 24'h00_000C;
   localparam logic [23:0] A_CMD    = 24'h00_0010;
   localparam logic [23:0] A_CTRL   = 24'h00_0014;
   localparam logic [23:0] A_STATUS = 24'h00_0018;

   logic [3:0]  state_q, state_d;
   logic        ph_q, ph_d;
   logic        prio_q, prio_d;
   logic        sel_q, sel_d;
   logic        lwe_q, lwe_d;
   logic [23:0] laddr_q, laddr_d;
   logic [31:0] lwdata_q, lwdata_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic        rv0_q, rv0_d, rv1_q, rv1_d;
   logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d;
   logic        cwe_q, cwe_d, cre_q, cre_d;
   logic [23:0] caddr_q, caddr_d;
   logic [31:0] cwdata_q, cwdata_d;
   logic        busy_q, busy_d;
   logic        launch, req0, req1, win;
`ifdef QSPI_ARB_TIMEOUT_EN
   logic [PCNT_W-1:0] pcnt_q, pcnt_d;
   logic              to_q, to_d;
   logic              err_q, err_d;
`endif

   // Next-state, register-bus sequencing and response generation.
   always_comb begin
      state_d  = state_q;
      ph_d     = ph_q;
      prio_d   = prio_q;
      sel_d    = sel_q;
      lwe_d    = lwe_q;
      laddr_d  = laddr_q;
      lwdata_d = lwdata_q;
      rbuf_d   = rbuf_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      rv0_d    = 1'b0;
      rv1_d    = 1'b0;
      rd0_d    = rd0_q;
      rd1_d    = rd1_q;
      cwe_d    = 1'b0;
      cre_d    = 1'b0;
      caddr_d  = caddr_q;
      cwdata_d = cwdata_q;
      launch   = 1'b0;
`ifdef QSPI_ARB_TIMEOUT_EN
      pcnt_d   = pcnt_q;
      to_d     = to_q;
      err_d    = 1'b0;
`endif
      // A port whose completion pulse is showing is still holding req for the finished transfer.
      req0 = p0_req_i && !rv0_q;
      req1 = p1_req_i && !rv1_q;
      win  = (req0 && req1) ? prio_q : req1;

      case (state_q)
         S_INIT: begin
            if (!ph_q) begin
               ph_d     = 1'b1;
               cwe_d    = 1'b1;
               caddr_d  = A_CFG;
               cwdata_d = CFG_WORD;
            end else begin
               ph_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (req0 || req1) begin
               state_d  = S_GRANT;
               sel_d    = win;
               gnt0_d   = !win;
               gnt1_d   = win;
               lwe_d    = win ? p1_we_i : 1'b0;
               laddr_d  = win ? p1_addr_i : p0_addr_i;
               lwdata_d = win ? p1_wdata_i : 32'h0;
            end
         end
         S_GRANT: begin
            state_d = lwe_q ? S_WDAT : S_ADDR;
            ph_d    = 1'b0;
            launch  = 1'b1;
`ifdef QSPI_ARB_TIMEOUT_EN
            pcnt_d  = '0;
            to_d    = 1'b0;
`endif
         end
`ifdef QSPI_ARB_TIMEOUT_EN
         S_WDAT, S_ADDR, S_CMD, S_START, S_CLRS, S_ABRT: begin
`else
         S_WDAT, S_ADDR, S_CMD, S_START, S_CLRS: begin
`endif
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d   = 1'b0;
               launch = 1'b1;
               case (state_q)
                  S_WDAT:  state_d = S_ADDR;
                  S_ADDR:  state_d = S_CMD;
                  S_CMD:   state_d = S_START;
                  S_START: state_d = S_CLRS;
                  S_CLRS:  state_d = S_POLL;
                  default: begin
                     state_d = S_RESP;
                     launch  = 1'b0;
                  end
               endcase
            end
         end
         S_POLL: begin
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d   = 1'b0;
               launch = 1'b1;
               if (core_rdata_i[0]) begin
`ifdef QSPI_ARB_TIMEOUT_EN
                  if (32'(pcnt_q) + 32'd1 >= POLL_MAX) begin
                     state_d = S_ABRT;
                     to_d    = 1'b1;
                     rbuf_d  = 32'hDEAD_BEEF;
                  end else begin
                     pcnt_d  = pcnt_q + PCNT_W'(1);
                     state_d = S_POLL;
                  end
`else
                  state_d = S_POLL;
`endif
               end else begin
                  state_d = S_RDAT;
               end
            end
         end
         // Writes spend this slot idle so both directions share the same response timing.
         S_RDAT: begin
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d    = 1'b0;
               rbuf_d  = lwe_q ? 32'h0 : core_rdata_i;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            prio_d  = !sel_q;
            rv0_d   = !sel_q;
            rv1_d   = sel_q;
            if (sel_q) rd1_d = rbuf_q;
            else       rd0_d = rbuf_q;
`ifdef QSPI_ARB_TIMEOUT_EN
            err_d   = to_q;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (launch) begin
         case (state_d)
            S_WDAT:  begin cwe_d = 1'b1; caddr_d = A_WDATA; cwdata_d = lwdata_q;         end
            S_ADDR:  begin cwe_d = 1'b1; caddr_d = A_ADDR;  cwdata_d = {8'h00, laddr_q}; end
            S_CMD:   begin
               cwe_d    = 1'b1;
               caddr_d  = A_CMD;
               cwdata_d = {24'h0, (lwe_q ? WR_CMD : RD_CMD)};
            end
            S_START: begin cwe_d = 1'b1; caddr_d = A_CTRL;  cwdata_d = 32'h21; end
            S_CLRS:  begin cwe_d = 1'b1; caddr_d = A_CTRL;  cwdata_d = 32'h20; end
`ifdef QSPI_ARB_TIMEOUT_EN
            S_ABRT:  begin cwe_d = 1'b1; caddr_d = A_CTRL;  cwdata_d = 32'h00; end
`endif
            S_POLL:  begin cre_d = 1'b1; caddr_d = A_STATUS; end
            S_RDAT:  begin
               if (!lwe_q) begin
                  cre_d   = 1'b1;
                  caddr_d = A_RDATA;
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_INIT;
         ph_q     <= 1'b0;
         prio_q   <= 1'b0;
         sel_q    <= 1'b0;
         lwe_q    <= 1'b0;
         laddr_q  <= 24'h0;
         lwdata_q <= 32'h0;
         rbuf_q   <= 32'h0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         rv0_q    <= 1'b0;
         rv1_q    <= 1'b0;
         rd0_q    <= 32'h0;
         rd1_q    <= 32'h0;
         cwe_q    <= 1'b0;
         cre_q    <= 1'b0;
         caddr_q  <= 24'h0;
         cwdata_q <= 32'h0;
         busy_q   <= 1'b0;
`ifdef QSPI_ARB_TIMEOUT_EN
         pcnt_q   <= '0;
         to_q     <= 1'b0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ph_q     <= ph_d;
         prio_q   <= prio_d;
         sel_q    <= sel_d;
         lwe_q    <= lwe_d;
         laddr_q  <= laddr_d;
         lwdata_q <= lwdata_d;
         rbuf_q   <= rbuf_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         rv0_q    <= rv0_d;
         rv1_q    <= rv1_d;
         rd0_q    <= rd0_d;
         rd1_q    <= rd1_d;
         cwe_q    <= cwe_d;
         cre_q    <= cre_d;
         caddr_q  <= caddr_d;
         cwdata_q <= cwdata_d;
         busy_q   <= busy_d;
`ifdef QSPI_ARB_TIMEOUT_EN
         pcnt_q   <= pcnt_d;
         to_q     <= to_d;
         err_q    <= err_d;
`endif
      end
   end

   assign p0_gnt_o     = gnt0_q;
   assign p0_rvalid_o  = rv0_q;
   assign p0_rdata_o   = rd0_q;
   assign p1_gnt_o     = gnt1_q;
   assign p1_rvalid_o  = rv1_q;
   assign p1_rdata_o   = rd1_q;
   assign core_we_o    = cwe_q;
   assign core_re_o    = cre_q;
   assign core_addr_o  = caddr_q;
   assign core_wdata_o = cwdata_q;
   assign busy_o       = busy_q;
`ifdef QSPI_ARB_TIMEOUT_EN
   assign err_o        = err_q;
`endif

endmodule

// File: tb/tb_qspi_xip_arbiter.sv
// Directed bench for qspi_xip_arbiter: a qspi_core register model plus scoreboards for
// core writes, grant order and read responses (latency, data, err when the timeout is built in).
module tb_qspi_xip_arbiter;

   localparam int TB_POLL_MAX = 4;

   typedef struct {
      logic [31:0] data;
      int          lat;
      logic        err;
   } rd_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p1_req, p1_we;
   logic [23:0] p0_addr, p1_addr;
   logic [31:0] p1_wdata;
   logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
   logic [31:0] p0_rdata, p1_rdata;
   logic        core_we, core_re, busy;
   logic [23:0] core_addr;
   logic [31:0] core_wdata, core_rdata;
`ifdef QSPI_ARB_TIMEOUT_EN
   logic        err;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [55:0] exp_wr[$];
   bit          exp_gnt[$];
   rd_t         exp_rd0[$];
   rd_t         exp_rd1[$];
   int          busy_q[$];
   logic [31:0] rd_q[$];
   int          busy_left;
   bit          cfg_seen;
   bit          prev_we;
   logic [55:0] prev_aw;
   int          gnt_cyc0, gnt_cyc1;

   always #5 clk = ~clk;

`ifdef QSPI_ARB_TIMEOUT_EN
   qspi_xip_arbiter #(.POLL_MAX(TB_POLL_MAX)) dut (
      .clk_i(clk), .rst_i(rst),
      .p0_req_i(p0_req), .p0_addr_i(p0_addr),
      .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
      .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
      .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
      .core_we_o(core_we), .core_re_o(core_re), .core_addr_o(core_addr),
      .core_wdata_o(core_wdata), .core_rdata_i(core_rdata),
      .err_o(err),
      .busy_o(busy)
   );
`else
   qspi_xip_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .p0_req_i(p0_req), .p0_addr_i(p0_addr),
      .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
      .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
      .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
      .core_we_o(core_we), .core_re_o(core_re), .core_addr_o(core_addr),
      .core_wdata_o(core_wdata), .core_rdata_i(core_rdata),
      .busy_o(busy)
   );
`endif

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // qspi_core register model: busy count per transfer taken at CTRL start, read data from a queue.
   always @(posedge clk) begin
      if (rst) begin
         core_rdata <= 32'h0;
         busy_left  <= 0;
      end else begin
         core_rdata <= 32'h0;
         if (core_we && core_addr == 24'h14 && core_wdata == 32'h21)
            busy_left <= (busy_q.size() != 0) ? busy_q.pop_front() : 0;
         if (core_re && core_addr == 24'h18) begin
            core_rdata <= {31'h0, (busy_left != 0)};
            if (busy_left != 0) busy_left <= busy_left - 1;
         end
         if (core_re && core_addr == 24'h08)
            core_rdata <= (rd_q.size() != 0) ? rd_q.pop_front() : 32'hBAD0_0000;
      end
   end

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      rd_t r;
      logic [55:0] w;
      cyc++;
      if (!rst) begin
         if (prev_we) chk("we_gap", 128'({core_we, core_addr, core_wdata}), 128'({1'b0, prev_aw}));
         prev_we = core_we;
         prev_aw = {core_addr, core_wdata};
         if (core_we) begin
            chk("wr_expected", 128'(exp_wr.size() != 0), 128'(1));
            if (exp_wr.size() != 0) begin
               w = exp_wr.pop_front();
               chk("core_wr", 128'({core_addr, core_wdata}), 128'(w));
            end
            if (core_addr == 24'h0) cfg_seen = 1'b1;
         end
         if (p0_gnt || p1_gnt) begin
            chk("gnt_exclusive", 128'(p0_gnt && p1_gnt), 128'(0));
            chk("gnt_after_cfg", 128'(cfg_seen), 128'(1));
            chk("busy_at_gnt", 128'(busy), 128'(1));
            chk("gnt_expected", 128'(exp_gnt.size() != 0), 128'(1));
            if (exp_gnt.size() != 0) chk("gnt_port", 128'(p1_gnt), 128'(exp_gnt.pop_front()));
            if (p0_gnt) gnt_cyc0 = cyc;
            if (p1_gnt) gnt_cyc1 = cyc;
         end
         if (p0_rvalid) begin
            chk("rv0_expected", 128'(exp_rd0.size() != 0), 128'(1));
            if (exp_rd0.size() != 0) begin
               r = exp_rd0.pop_front();
               chk("p0_rdata", 128'(p0_rdata), 128'(r.data));
               chk("p0_latency", 128'(cyc - gnt_cyc0), 128'(r.lat));
            end
         end
         if (p1_rvalid) begin
            chk("rv1_expected", 128'(exp_rd1.size() != 0), 128'(1));
            if (exp_rd1.size() != 0) begin
               r = exp_rd1.pop_front();
               chk("p1_rdata", 128'(p1_rdata), 128'(r.data));
               chk("p1_latency", 128'(cyc - gnt_cyc1), 128'(r.lat));
`ifdef QSPI_ARB_TIMEOUT_EN
               chk("p1_err", 128'(err), 128'(r.err));
`endif
            end
         end
      end else begin
         prev_we = 1'b0;
      end
   end

   task automatic push_txn(input bit port, input bit we, input logic [23:0] addr,
                           input logic [31:0] wd, input int polls, input logic [31:0] rd,
                           input bit abort);
      rd_t r;
      if (we) exp_wr.push_back({24'h04, wd});
      exp_wr.push_back({24'h0C, 8'h00, addr});
      exp_wr.push_back({24'h10, 24'h0, (we ? 8'h32 : 8'hEB)});
      exp_wr.push_back({24'h14, 32'h21});
      exp_wr.push_back({24'h14, 32'h20});
      if (abort) exp_wr.push_back({24'h14, 32'h00});
      busy_q.push_back(polls);
      if (!we && !abort) rd_q.push_back(rd);
      r.data = abort ? 32'hDEAD_BEEF : (we ? 32'h0 : rd);
      r.lat  = abort ? 14 + 2 * (TB_POLL_MAX - 1) : (we ? 16 : 14) + 2 * polls;
      r.err  = abort;
      if (port) exp_rd1.push_back(r);
      else      exp_rd0.push_back(r);
      exp_gnt.push_back(port);
   endtask

   task automatic wait_rv(input bit port);
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         seen = port ? p1_rvalid : p0_rvalid;
      end
      chk(port ? "p1_rvalid_seen" : "p0_rvalid_seen", 128'(seen), 128'(1));
   endtask

   task automatic check_outputs_zero(input string tag);
      chk(tag, 128'({p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
                     core_we, core_re, core_addr, core_wdata, busy}), 128'(0));
`ifdef QSPI_ARB_TIMEOUT_EN
      chk({tag, "_err"}, 128'(err), 128'(0));
`endif
   endtask

   initial begin
      bit seen;
      rst = 1'b1;
      p0_req = 1'b0; p0_addr = 24'h0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = 24'h0; p1_wdata = 32'h0;
      cfg_seen = 1'b0; prev_we = 1'b0; gnt_cyc0 = 0; gnt_cyc1 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset_outputs");

      // Release with p0 already requesting: CFG must come first, then the read with 3 busy polls.
      @(posedge clk); #1;
      exp_wr.push_back({24'h00, 32'h0F20_8182});
      push_txn(1'b0, 1'b0, 24'h00_1000, 32'h0, 3, 32'hABAB_ABAB, 1'b0);
      rst = 1'b0; p0_addr = 24'h00_1000; p0_req = 1'b1;
      wait_rv(1'b0);
      @(posedge clk); #1 p0_req = 1'b0;
      repeat (3) @(posedge clk); #1;

      // p1 write, no busy polls.
      push_txn(1'b1, 1'b1, 24'h00_0040, 32'h00FA_BCDE, 0, 32'h0, 1'b0);
      p1_we = 1'b1; p1_addr = 24'h00_0040; p1_wdata = 32'h00FA_BCDE; p1_req = 1'b1;
      wait_rv(1'b1);
      @(posedge clk); #1 p1_req = 1'b0; p1_we = 1'b0;
      repeat (2) @(posedge clk); #1;

      // p1 read, one busy poll.
      push_txn(1'b1, 1'b0, 24'h00_0200, 32'h0, 1, 32'h1234_5678, 1'b0);
      p1_addr = 24'h00_0200; p1_req = 1'b1;
      wait_rv(1'b1);
      @(posedge clk); #1 p1_req = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Both ports requesting back to back: grants must alternate p0, p1, p0, p1.
      push_txn(1'b0, 1'b0, 24'h00_0A00, 32'h0, 0, 32'hA0A0_0001, 1'b0);
      push_txn(1'b1, 1'b0, 24'h00_0B00, 32'h0, 0, 32'hB0B0_0001, 1'b0);
      push_txn(1'b0, 1'b0, 24'h00_0A04, 32'h0, 0, 32'hA0A0_0002, 1'b0);
      push_txn(1'b1, 1'b0, 24'h00_0B04, 32'h0, 0, 32'hB0B0_0002, 1'b0);
      p0_addr = 24'h00_0A00; p1_addr = 24'h00_0B00;
      p0_req = 1'b1; p1_req = 1'b1;
      fork
         begin
            wait_rv(1'b0);
            @(posedge clk); #1 p0_addr = 24'h00_0A04;
            wait_rv(1'b0);
            @(posedge clk); #1 p0_req = 1'b0;
         end
         begin
            wait_rv(1'b1);
            @(posedge clk); #1 p1_addr = 24'h00_0B04;
            wait_rv(1'b1);
            @(posedge clk); #1 p1_req = 1'b0;
         end
      join
      repeat (2) @(posedge clk); #1;

      // Reset while polling a busy core: outputs clear at once, CFG rewritten before the next grant.
      push_txn(1'b0, 1'b0, 24'h00_3000, 32'h0, 5, 32'h0BAD_0BAD, 1'b0);
      p0_addr = 24'h00_3000; p0_req = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = core_re && (core_addr == 24'h18);
      end
      chk("poll_reached", 128'(seen), 128'(1));
      rst = 1'b1;
      #1 check_outputs_zero("reset_in_poll");
      p0_req = 1'b0;
      exp_wr.delete(); exp_gnt.delete(); exp_rd0.delete(); exp_rd1.delete();
      busy_q.delete(); rd_q.delete();
      cfg_seen = 1'b0;
      repeat (3) @(posedge clk); #1;
      exp_wr.push_back({24'h00, 32'h0F20_8182});
      push_txn(1'b0, 1'b0, 24'h00_3000, 32'h0, 0, 32'h55AA_55AA, 1'b0);
      rst = 1'b0; p0_req = 1'b1;
      wait_rv(1'b0);
      @(posedge clk); #1 p0_req = 1'b0;
      repeat (2) @(posedge clk); #1;

`ifdef QSPI_ARB_TIMEOUT_EN
      // Core stuck busy: abort after TB_POLL_MAX polls.
      push_txn(1'b1, 1'b0, 24'h00_4000, 32'h0, 100, 32'h0, 1'b1);
      p1_addr = 24'h00_4000; p1_req = 1'b1;
      wait_rv(1'b1);
      @(posedge clk); #1 p1_req = 1'b0;
      repeat (2) @(posedge clk); #1;
`endif

      repeat (3) @(negedge clk);
      chk("wr_queue_drained", 128'(exp_wr.size()), 128'(0));
      chk("gnt_queue_drained", 128'(exp_gnt.size()), 128'(0));
      chk("rd0_queue_drained", 128'(exp_rd0.size()), 128'(0));
      chk("rd1_queue_drained", 128'(exp_rd1.size()), 128'(0));
      chk("idle_at_end", 128'(busy), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
